// File: rtl/elgamal_pkg.sv
// Shared types and constants for the ElGamal decrypt datapath.
package elgamal_pkg;

  localparam int SIZE_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    EXP,
    FINAL,
    DONE
  } state_t;

  // Cycles from input acceptance to the first cycle output_tvalid is high.
  function automatic int latency(input int size);
    return (size + 1) * (size + 1) + 2;
  endfunction

  localparam int LATENCY = latency(SIZE_DEFAULT);

endpackage

// File: rtl/elgamal_decrypt_mod_mul_serial.sv
// Bit-serial interleaved modular multiplier, MSB first.
// Start is sampled at cycle 0; done and result are valid at cycle SIZE.
module mod_mul_serial #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] p,
  output logic [SIZE-1:0] result,
  output logic            done
);

  localparam int CW = $clog2(SIZE + 1);

  logic [SIZE-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  // One interleaved step: double then conditionally add, each followed by one
  // conditional subtract. Inputs below p keep every intermediate within SIZE+1 bits.
  function automatic logic [SIZE-1:0] mod_step(input logic [SIZE-1:0] acc,
                                               input logic [SIZE-1:0] av,
                                               input logic [SIZE-1:0] pv,
                                               input logic            bit_set);
    logic [SIZE:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, pv}) t = t - {1'b0, pv};
    if (bit_set) begin
      t = t + {1'b0, av};
      if (t >= {1'b0, pv}) t = t - {1'b0, pv};
    end
    return t[SIZE-1:0];
  endfunction

  // The first step is folded into the start cycle so SIZE steps finish by cycle SIZE.
  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = a;
      p_d    = p;
      b_d    = {b[SIZE-2:0], 1'b0};
      acc_d  = mod_step('0, a, p, b[SIZE-1]);
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CW'(SIZE)) begin
        busy_d = 1'b0;
      end else begin
        acc_d = mod_step(acc_q, a_q, p_q, b_q[SIZE-1]);
        b_d   = {b_q[SIZE-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Control state: reset returns the multiplier to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers carry no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    a_q   <= a_d;
    b_q   <= b_d;
    p_q   <= p_d;
  end

  assign done   = busy_q && (cnt_q == CW'(SIZE));
  assign result = acc_q;

endmodule

// File: rtl/elgamal_decrypt.sv
// ElGamal decryption m = c2 * c1^(p-1-x) mod p, constant-time square-and-multiply.
module elgamal_decrypt
  import elgamal_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] c1_tdata,
  input  logic            c1_tvalid,
  output logic            c1_tready,
  input  logic [SIZE-1:0] c2_tdata,
  input  logic            c2_tvalid,
  output logic            c2_tready,
  input  logic [SIZE-1:0] key_tdata,
  input  logic            key_tvalid,
  output logic            key_tready,
  input  logic [SIZE-1:0] modulus_tdata,
  input  logic            modulus_tvalid,
  output logic            modulus_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tvalid,
  input  logic            output_tready
);

  localparam int CW = $clog2(SIZE + 1);

  state_t          state_q, state_d;
  logic [SIZE-1:0] c1_q, c1_d, c2_q, c2_d, x_q, x_d, p_q, p_d;
  logic [SIZE-1:0] e_q, e_d, r_q, r_d, b_q, b_d, m_q, m_d;
  logic [CW-1:0]   i_q, i_d;
  logic            wait_q, wait_d;
  logic            accept, mul_start, sq_start;
  logic [SIZE-1:0] mul_a, mul_b, mul_res, sq_res;
  logic            mul_done, sq_done;

  assign accept = (state_q == IDLE) && c1_tvalid && c2_tvalid && key_tvalid && modulus_tvalid;

  // FINAL reuses the r*b multiplier for c2*r.
  assign mul_a = (state_q == FINAL) ? c2_q : r_q;
  assign mul_b = (state_q == FINAL) ? r_q : b_q;

  mod_mul_serial #(.SIZE(SIZE)) u_mul_rb (
    .clk(clk), .rst(rst), .start(mul_start), .a(mul_a), .b(mul_b), .p(p_q),
    .result(mul_res), .done(mul_done)
  );

  mod_mul_serial #(.SIZE(SIZE)) u_mul_bb (
    .clk(clk), .rst(rst), .start(sq_start), .a(b_q), .b(b_q), .p(p_q),
    .result(sq_res), .done(sq_done)
  );

  // Next-state and datapath updates; e shifts right so bit 0 is always the current key bit.
  always_comb begin
    state_d   = state_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    x_d       = x_q;
    p_d       = p_q;
    e_d       = e_q;
    r_d       = r_q;
    b_d       = b_q;
    m_d       = m_q;
    i_d       = i_q;
    wait_d    = wait_q;
    mul_start = 1'b0;
    sq_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          c1_d    = c1_tdata;
          c2_d    = c2_tdata;
          x_d     = key_tdata;
          p_d     = modulus_tdata;
          state_d = PREP;
        end
      end
      PREP: begin
        e_d     = p_q - SIZE'(1) - x_q;
        r_d     = SIZE'(1);
        b_d     = c1_q;
        i_d     = '0;
        wait_d  = 1'b0;
        state_d = EXP;
      end
      EXP: begin
        if (!wait_q) begin
          mul_start = 1'b1;
          sq_start  = 1'b1;
          wait_d    = 1'b1;
        end else if (mul_done && sq_done) begin
          b_d    = sq_res;
          if (e_q[0]) r_d = mul_res;
          e_d    = e_q >> 1;
          i_d    = i_q + CW'(1);
          wait_d = 1'b0;
          if (i_q == CW'(SIZE - 1)) state_d = FINAL;
        end
      end
      FINAL: begin
        if (!wait_q) begin
          mul_start = 1'b1;
          wait_d    = 1'b1;
        end else if (mul_done) begin
          m_d     = mul_res;
          wait_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (output_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible output state, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      i_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      i_q     <= i_d;
      m_q     <= m_d;
    end
  end

  // Operand and exponentiation registers carry no reset.
  always_ff @(posedge clk) begin
    c1_q <= c1_d;
    c2_q <= c2_d;
    x_q  <= x_d;
    p_q  <= p_d;
    e_q  <= e_d;
    r_q  <= r_d;
    b_q  <= b_d;
  end

  assign c1_tready      = accept;
  assign c2_tready      = accept;
  assign key_tready     = accept;
  assign modulus_tready = accept;
  assign output_tvalid  = (state_q == DONE);
  assign output_tdata   = m_q;

endmodule

// File: tb/tb_elgamal_decrypt.sv
// Scoreboard bench for elgamal_decrypt at SIZE=8.
module tb_elgamal_decrypt;
  import elgamal_pkg::*;

  localparam int W   = 8;
  localparam int LAT = latency(W);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] c1_tdata = '0, c2_tdata = '0, key_tdata = '0, modulus_tdata = '0;
  logic         c1_tvalid = 1'b0, c2_tvalid = 1'b0, key_tvalid = 1'b0, modulus_tvalid = 1'b0;
  logic         c1_tready, c2_tready, key_tready, modulus_tready;
  logic [W-1:0] output_tdata;
  logic         output_tvalid;
  logic         output_tready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  longint exp_q[$];
  int     acc_q[$];

  elgamal_decrypt #(.SIZE(W)) dut (
    .clk(clk), .rst(rst),
    .c1_tdata(c1_tdata), .c1_tvalid(c1_tvalid), .c1_tready(c1_tready),
    .c2_tdata(c2_tdata), .c2_tvalid(c2_tvalid), .c2_tready(c2_tready),
    .key_tdata(key_tdata), .key_tvalid(key_tvalid), .key_tready(key_tready),
    .modulus_tdata(modulus_tdata), .modulus_tvalid(modulus_tvalid), .modulus_tready(modulus_tready),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: c2 * c1^((p-1-x) mod 2^W) mod p with plain integer arithmetic.
  function automatic longint model(input longint c1, input longint c2, input longint x, input longint p);
    longint e, base, res;
    e    = (p - 1 - x) & ((64'd1 << W) - 1);
    base = c1 % p;
    res  = 1;
    while (e > 0) begin
      if (e[0]) res = (res * base) % p;
      base = (base * base) % p;
      e = e >> 1;
    end
    return (c2 * res) % p;
  endfunction

  // Scoreboard: push on input handshake, check latency on rising tvalid, pop on output handshake.
  initial begin
    logic prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        prev_vld = 1'b0;
      end else begin
        if (output_tvalid && !prev_vld) begin
          if (acc_q.size() > 0) chk("latency", cyc - acc_q[0], LAT);
          else chk("spurious_valid", 1, 0);
        end
        if (output_tvalid && output_tready && exp_q.size() > 0) begin
          chk("m", output_tdata, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        if (c1_tready && c1_tvalid) begin
          exp_q.push_back(model(c1_tdata, c2_tdata, key_tdata, modulus_tdata));
          acc_q.push_back(cyc);
        end
        prev_vld = output_tvalid;
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] k, input logic [W-1:0] m);
    c1_tdata = a; c2_tdata = b; key_tdata = k; modulus_tdata = m;
    c1_tvalid = 1'b1; c2_tvalid = 1'b1; key_tvalid = 1'b1; modulus_tvalid = 1'b1;
  endtask

  task automatic drop_valid();
    c1_tvalid = 1'b0; c2_tvalid = 1'b0; key_tvalid = 1'b0; modulus_tvalid = 1'b0;
  endtask

  task automatic wait_accept(output int a_cyc);
    bit seen;
    seen  = 1'b0;
    a_cyc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (c1_tready) begin
        seen  = 1'b1;
        a_cyc = cyc;
      end
    end
    if (!seen) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int n = 0; n < 300 && !empty; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !output_tvalid) empty = 1'b1;
    end
    if (!empty) chk("drain_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] k, input logic [W-1:0] m);
    int a_cyc;
    @(posedge clk); #1;
    drive(a, b, k, m);
    wait_accept(a_cyc);
    @(posedge clk); #1;
    drop_valid();
    drain();
  endtask

  initial begin
    int  a_cyc;
    bit  seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", {c1_tready, c2_tready, key_tready, modulus_tready}, 0);
    chk("rst_tvalid", output_tvalid, 0);
    chk("rst_tdata", output_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic decrypt and corner values.
    run_op(8'd10, 8'd14, 8'd6, 8'd23);
    run_op(8'd10, 8'd14, 8'd0, 8'd23);
    run_op(8'd0, 8'd14, 8'd6, 8'd23);
    run_op(8'd250, 8'd3, 8'd1, 8'd251);

    // Join: three of four valids never start an operation.
    @(posedge clk); #1;
    drive(8'd10, 8'd14, 8'd6, 8'd23);
    modulus_tvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("join_tready", {c1_tready, c2_tready, key_tready, modulus_tready}, 0);
    end
    @(posedge clk); #1;
    drop_valid();

    // Backpressure: result held while output_tready is low, new inputs waiting.
    output_tready = 1'b0;
    drive(8'd10, 8'd14, 8'd6, 8'd23);
    wait_accept(a_cyc);
    @(posedge clk); #1;
    drive(8'd0, 8'd14, 8'd6, 8'd23);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (output_tvalid) seen = 1'b1;
    end
    if (!seen) chk("bp_timeout", 0, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_tvalid", output_tvalid, 1);
      chk("bp_tdata", output_tdata, 10);
      chk("bp_tready", c1_tready, 0);
    end
    @(posedge clk); #1;
    output_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hs_tvalid_drop", output_tvalid, 0);
    chk("hs_tready_idle", c1_tready, 1);
    @(posedge clk); #1;
    drop_valid();
    drain();

    // Reset mid-EXP aborts the operation.
    @(posedge clk); #1;
    drive(8'd10, 8'd14, 8'd6, 8'd23);
    wait_accept(a_cyc);
    @(posedge clk); #1;
    drop_valid();
    while (cyc < a_cyc + 40) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tready", {c1_tready, c2_tready, key_tready, modulus_tready}, 0);
    chk("abort_tvalid", output_tvalid, 0);
    run_op(8'd10, 8'd14, 8'd6, 8'd23);

    // Back-to-back with inputs held valid.
    @(posedge clk); #1;
    drive(8'd10, 8'd14, 8'd0, 8'd23);
    wait_accept(a_cyc);
    @(posedge clk); #1;
    drive(8'd250, 8'd3, 8'd1, 8'd251);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (output_tvalid && output_tready) seen = 1'b1;
    end
    if (!seen) chk("b2b_timeout", 0, 1);
    @(negedge clk);
    chk("b2b_accept", c1_tready, 1);
    chk("b2b_tvalid", output_tvalid, 0);
    @(posedge clk); #1;
    drop_valid();
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/elgamal_decrypt.md
# elgamal_decrypt

- Computes ElGamal plaintext m = c2 · c1^(p−1−x) mod p from ciphertext (c1, c2), private key x and prime modulus p.
- Decrypt-side counterpart of the encryption datapath; uses Fermat's inverse, so no division unit is needed.
- Inputs and output are AXI-stream style.
- Fixed latency independent of key bits (constant-time), built on two instances of a bit-serial modular multiplier.

## Interface
- SIZE, 64, operand width in bits for c1, c2, x, p and m.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- c1_tdata / c1_tvalid / c1_tready  in/in/out  SIZE/1/1  ciphertext part 1.
- c2_tdata / c2_tvalid / c2_tready  in/in/out  SIZE/1/1  ciphertext part 2.
- key_tdata / key_tvalid / key_tready  in/in/out  SIZE/1/1  private key x.
- modulus_tdata / modulus_tvalid / modulus_tready  in/in/out  SIZE/1/1  prime p.
- output_tdata / output_tvalid / output_tready  out/out/in  SIZE/1/1  plaintext m.

## Operation
- States: IDLE, PREP, EXP, FINAL, DONE.
- **IDLE**
  - All four treadys are asserted together, only in IDLE and only when all four tvalids are high (join).
  - Acceptance = IDLE & all tvalid; the four operands are registered on that edge. Partial valid: nothing accepted, treadys stay low.
- **PREP** (1 cycle)
  - e = p − 1 − x, SIZE-bit, wrap-around modulo 2^SIZE.
  - r = 1, b = c1, bit index i = 0.
- **EXP** (SIZE iterations, right-to-left square-and-multiply)
  - Each iteration starts both multipliers in the same cycle: r·b mod p and b·b mod p.
  - On done: b ← b·b mod p. r ← r·b mod p only if e[i] = 1; otherwise the product is discarded. i increments.
  - All SIZE bits are always processed, including leading zeros.
- **FINAL**: one multiply m = c2·r mod p.
- **DONE**
  - output_tvalid = 1; output_tdata holds m, stable until output_tready.
  - On handshake, output_tvalid drops the next cycle and the state returns to IDLE. No new input is accepted before that.
- Operand contract (caller-guaranteed): p odd prime ≥ 3, p < 2^SIZE, c1 < p, c2 < p, x ≤ p−2.
  - Violations give an undefined m but identical latency; the block never hangs.
- x = 0 is legal: s = 1 and m = c2. c1 = 0 gives m = 0.

## Timing
- Reset values: all treadys 0, output_tvalid 0, output_tdata 0, state IDLE, multipliers idle.
- rst in any state (including mid-EXP or DONE with tvalid high) aborts the operation. IDLE and the reset values hold from the next cycle; the partial result is lost.
- Multiplier latency: start sampled at cycle 0 → done and result valid at cycle SIZE.
  - One iteration or the FINAL step is SIZE+1 cycles, including the start cycle.
- Acceptance at cycle A:
  - PREP at A+1.
  - EXP spans A+2 … A+1+SIZE·(SIZE+1).
  - FINAL follows.
  - output_tvalid first high at A+2+(SIZE+1)^2. This is 83 for SIZE=8 and 4227 for SIZE=64.
- Throughput: one operation per (SIZE+1)^2+3 cycles minimum, with output_tready held high.

## Structure
- Package elgamal_pkg:
  - FSM state enum.
  - Default SIZE constant.
  - Latency constant (SIZE+1)^2+2, shared with the bench.
- Sub-module mod_mul_serial, two instances.
  - Bit-serial interleaved MSB-first multiplier: acc ← 2·acc mod p, then acc ← acc + a mod p if b bit set.
  - Intermediates are SIZE+1 bits; each reduction is one conditional subtract.
  - Ports: clk, rst, start, a, b, p, result, done.
- The top-level FSM holds e, r, b, i and the operand registers.

## Test plan
All scenarios use SIZE=8.
- Basic decrypt: c1=10, c2=14, x=6, p=23 → m=10, with output_tvalid exactly 83 cycles after acceptance.
- Corner values:
  - x=0, c1=10, c2=14, p=23 → m=14.
  - c1=0, c2=14, x=6, p=23 → m=0.
- Full width: p=251, c1=250, c2=3, x=1 → m=248; latency unchanged.
- Join and backpressure:
  - Only three tvalids high for 20 cycles → all treadys stay 0.
  - After m is produced, output_tready low for 10 cycles → tdata/tvalid stable, no input accepted.
  - Then handshake → tvalid 0 next cycle, treadys reassert in IDLE.
- Reset mid-EXP: rst at cycle A+40 → treadys and output_tvalid 0 next cycle. A fresh operation (c1=10, c2=14, x=6, p=23) then yields m=10 with nominal latency.
- Back-to-back: two operations with inputs held valid → second accepted the cycle after the first output handshake; both results correct.
